// File: rtl/alu_md.sv
// alu_md: registered ALU with iterative unsigned multiply/divide into HI/LO and valid/ready handshake
module alu_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alucontrol,
    output logic [WIDTH-1:0] s,
    output logic             zero,
    output logic             overflow,
    output logic             out_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] ph_q, ph_d, pl_q, pl_d, op_q, op_d;
    logic [WIDTH-1:0] s_q, s_d, hi_q, hi_d, lo_q, lo_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, ov_q, ov_d;
    logic             accept;
    logic [WIDTH-1:0] sum, diff, alu_r, it_hi, it_lo;
    logic             alu_ovf;
    logic [WIDTH:0]   msum, rsh, rdiff;

    assign in_ready  = state_q == IDLE;
    assign accept    = in_valid && in_ready;
    assign sum       = a + b;
    assign diff      = a - b;
    assign s         = s_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign out_valid = ov_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_comb begin
        alu_r   = '0;
        alu_ovf = 1'b0;
        case (alucontrol)
            4'b0000: alu_r = a & b;
            4'b0001: alu_r = a | b;
            4'b0010: begin
                alu_r   = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0011: alu_r = a ^ b;
            4'b0100: alu_r = ~(a | b);
            4'b0101: alu_r = {{(WIDTH-1){1'b0}}, a < b};
            4'b0110: begin
                alu_r   = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0111: alu_r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'b1010: alu_r = hi_q;
            4'b1011: alu_r = lo_q;
            default: alu_r = '0;
        endcase
    end

    // ph/pl hold the running {hi,lo} product, or {remainder, dividend->quotient} when dividing
    assign msum  = {1'b0, ph_q} + (pl_q[0] ? {1'b0, op_q} : '0);
    assign rsh   = {ph_q, pl_q[WIDTH-1]};
    assign rdiff = rsh - {1'b0, op_q};
    assign it_hi = state_q == MUL ? msum[WIDTH:1]
                 : (rdiff[WIDTH] ? rsh[WIDTH-1:0] : rdiff[WIDTH-1:0]);
    assign it_lo = state_q == MUL ? {msum[0], pl_q[WIDTH-1:1]}
                 : {pl_q[WIDTH-2:0], ~rdiff[WIDTH]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        pl_d    = pl_q;
        op_d    = op_q;
        s_d     = s_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        ov_d    = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (accept) begin
            if (alucontrol[3:1] == 3'b100) begin
                state_d = alucontrol[0] ? DIV : MUL;
                cnt_d   = CW'(WIDTH);
                ph_d    = '0;
                pl_d    = alucontrol[0] ? a : b;
                op_d    = alucontrol[0] ? b : a;
            end else begin
                s_d    = alu_r;
                zero_d = alu_r == '0;
                ovf_d  = alu_ovf;
                ov_d   = 1'b1;
            end
        end else if (!in_ready) begin
            cnt_d = cnt_q - CW'(1);
            ph_d  = it_hi;
            pl_d  = it_lo;
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                hi_d    = it_hi;
                lo_d    = it_lo;
                s_d     = it_lo;
                zero_d  = it_lo == '0;
                ovf_d   = 1'b0;
                ov_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ph_q    <= '0;
            pl_q    <= '0;
            op_q    <= '0;
            s_q     <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            ov_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            pl_q    <= pl_d;
            op_q    <= op_d;
            s_q     <= s_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            ov_q    <= ov_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed self-checking bench for alu_md at WIDTH=32 and WIDTH=8
module tb_alu_md;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  alucontrol = 4'd0;
    logic        in_valid = 1'b0, in_valid8 = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        in_ready, zero, overflow, out_valid;
    logic [31:0] s, hi, lo;
    logic        in_ready8, zero8, overflow8, out_valid8;
    logic [7:0]  s8, hi8, lo8;
    int          checks = 0, errors = 0;
    int          n;

    always #5 clk = ~clk;

    alu_md #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alucontrol(alucontrol), .s(s), .zero(zero),
        .overflow(overflow), .out_valid(out_valid), .hi(hi), .lo(lo)
    );

    alu_md #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .alucontrol(alucontrol), .s(s8), .zero(zero8),
        .overflow(overflow8), .out_valid(out_valid8), .hi(hi8), .lo(lo8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one op for exactly one edge, then scramble operands to prove they were sampled
    task automatic issue(input bit w8, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        alucontrol = op;
        a = x;
        b = y;
        a8 = x[7:0];
        b8 = y[7:0];
        if (w8) in_valid8 = 1'b1;
        else in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_valid8 = 1'b0;
        a = ~a;
        b = ~b;
        a8 = ~a8;
        b8 = ~b8;
    endtask

    task automatic wait_done(input bit w8, output int cyc);
        cyc = 0;
        while (!(w8 ? out_valid8 : out_valid) && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int pulses;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s", s, 0);
        check("rst_zero", zero, 1);
        check("rst_ovf", overflow, 0);
        check("rst_ov", out_valid, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_rdy", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        issue(1, 4'b1000, 32'hFF, 32'h2);
        check("m8_busy", in_ready8, 0);
        wait_done(1, n);
        check("m8_lat", n, 8);
        check("m8_hi", hi8, 8'h01);
        check("m8_lo", lo8, 8'hFE);
        issue(1, 4'b1001, 32'd200, 32'd3);
        wait_done(1, n);
        check("d8_lat", n, 8);
        check("d8_lo", lo8, 8'd66);
        check("d8_hi", hi8, 8'd2);
        check("d8_s", s8, 8'd66);
        check("d8_zero", zero8, 0);
        check("d8_ovf", overflow8, 0);

        issue(0, 4'b0010, 32'h7FFFFFFF, 32'h1);
        check("add_ov", out_valid, 1);
        check("add_s", s, 32'h80000000);
        check("add_ovf", overflow, 1);
        check("add_zero", zero, 0);
        @(posedge clk);
        #1;
        check("add_ov_drop", out_valid, 0);
        check("add_hold", s, 32'h80000000);
        issue(0, 4'b0110, 32'd5, 32'd5);
        check("sub_s", s, 0);
        check("sub_zero", zero, 1);
        check("sub_ovf", overflow, 0);
        issue(0, 4'b0110, 32'h80000000, 32'h1);
        check("sub_ovf_s", s, 32'h7FFFFFFF);
        check("sub_ovf_f", overflow, 1);
        issue(0, 4'b0111, 32'hFFFFFFFF, 32'h1);
        check("slt_neg", s, 1);
        check("slt_ovf", overflow, 0);
        issue(0, 4'b0101, 32'hFFFFFFFF, 32'h1);
        check("sltu", s, 0);
        issue(0, 4'b0111, 32'h80000000, 32'h7FFFFFFF);
        check("slt_wrap", s, 1);
        issue(0, 4'b0100, 32'h0, 32'h0);
        check("nor", s, 32'hFFFFFFFF);
        issue(0, 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
        check("and", s, 32'h00F0_1200);
        issue(0, 4'b0001, 32'hF000_0001, 32'h0000_0010);
        check("or", s, 32'hF000_0011);
        issue(0, 4'b0011, 32'hFFFF_0000, 32'h0F0F_0F0F);
        check("xor", s, 32'hF0F0_0F0F);

        issue(0, 4'b1000, 32'hFFFFFFFF, 32'h2);
        check("mul_busy", in_ready, 0);
        wait_done(0, n);
        check("mul_lat", n, 32);
        check("mul_hi", hi, 32'h1);
        check("mul_lo", lo, 32'hFFFFFFFE);
        check("mul_s", s, 32'hFFFFFFFE);
        check("mul_rdy", in_ready, 1);
        issue(0, 4'b1010, 32'h0, 32'h0);
        check("mfhi", s, 32'h1);
        issue(0, 4'b1011, 32'h0, 32'h0);
        check("mflo", s, 32'hFFFFFFFE);

        issue(0, 4'b1001, 32'd100, 32'd7);
        wait_done(0, n);
        check("div_lat", n, 32);
        check("div_lo", lo, 32'd14);
        check("div_hi", hi, 32'd2);
        issue(0, 4'b1001, 32'h1234, 32'h0);
        wait_done(0, n);
        check("dz_lat", n, 32);
        check("dz_lo", lo, 32'hFFFFFFFF);
        check("dz_hi", hi, 32'h1234);
        check("dz_zero", zero, 0);

        issue(0, 4'b1000, 32'd3, 32'd5);
        pulses = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("abort_pulses", pulses, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_s", s, 0);
        check("abort_zero", zero, 1);
        check("abort_rdy", in_ready, 1);
        issue(0, 4'b0010, 32'd3, 32'd4);
        check("add2_s", s, 32'd7);
        check("add2_ov", out_valid, 1);
        issue(0, 4'b1111, 32'd5, 32'd3);
        check("unk_s", s, 0);
        check("unk_ov", out_valid, 1);
        check("unk_zero", zero, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
